sos_cascade_sched: RTL and testbench
====================================

SOS_CASCADE_SCHED -- requirements
Module: sos_cascade_sched

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NSEC, 4, number of cascaded biquad sections, legal 1..8.
- W, 27, signed fixed-point sample/coefficient width.
- ONE, 27'h0800000, fixed-point 1.0 in the team multiplier format.
REQ-002 Ports (name, direction, width, meaning), one per line; reset reset, synchronous, active-high; clock aud_clk:
- aud_clk, in, 1, clock.
- reset, in, 1, sync active-high reset.
- sample_valid, in, 1, new input sample strobe.
- sample_in, in, W, input sample.
- sample_ready, out, 1, high when a sample can be accepted.
- flush, in, 1, clear all section history.
- cfg_we, in, 1, coefficient write request.
- cfg_sec, in, 3, target section.
- cfg_idx, in, 3, coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- cfg_data, in, W, coefficient value.
- cfg_ack, out, 1, write committed this cycle.
- dp_x, dp_x1, dp_x2, dp_y1, dp_y2, out, W each, operands to the shared biquad datapath.
- dp_b0, dp_b1, dp_b2, dp_a1, dp_a2, out, W each, coefficients of the active section.
- dp_y, in, W, combinational result from the datapath: b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2.
- out_valid, out, 1, one-cycle result strobe.
- out_data, out, W, cascade output.
- overrun, out, 1, sticky dropped-sample flag.

Function
REQ-003 The block SHALL hold, per section, 5 coefficients and 4 history registers (x1, x2, y1, y2), plus one running value cur.
REQ-004 The FSM SHALL have states IDLE, RUN and DONE; sample_ready SHALL equal (state==IDLE).
REQ-005 In IDLE with sample_valid=1 and flush=0, the block SHALL latch sample_in into cur, set sec=0 and enter RUN.
REQ-006 In each RUN cycle the block SHALL drive dp_x=cur, and drive dp_x1/x2/y1/y2 and dp_b*/a* from section sec.
REQ-007 At the end of each RUN cycle, section sec SHALL update x2<=x1, x1<=cur, y2<=y1, y1<=dp_y; cur SHALL be set to dp_y and sec SHALL increment.
REQ-008 After processing sec==NSEC-1, the FSM SHALL enter DONE; DONE SHALL set out_data<=cur, pulse out_valid for exactly 1 cycle, and return to IDLE.
REQ-009 Latency: for a sample accepted at edge T, out_valid SHALL be high in the cycle following edge T+NSEC+1; throughput is one sample per NSEC+2 cycles.
REQ-010 out_data SHALL hold its value until the next DONE.
REQ-011 Outside RUN, all dp_* outputs SHALL be 0.
REQ-012 sample_valid while sample_ready=0 SHALL be ignored and SHALL set overrun to 1; overrun clears only on reset.
REQ-013 cfg_ack SHALL equal cfg_we && state==IDLE (combinational); the write SHALL commit at that edge. While busy, the requester holds cfg_we and the write stalls.
REQ-014 A write to cfg_sec>=NSEC or cfg_idx>4 SHALL be acked with no effect.
REQ-015 A cfg write and a sample accept in the same IDLE cycle SHALL both occur; the new coefficient SHALL apply to that sample.
REQ-016 flush in IDLE SHALL zero all history registers; sample_valid in that same cycle SHALL be dropped and SHALL set overrun; flush outside IDLE SHALL be ignored.
REQ-017 All arithmetic is external to this block; it performs no saturation or rounding, and dp_y SHALL be stored unmodified.

Reset
REQ-018 Reset SHALL force IDLE, sec=0, cur=0, all history=0, out_data=0, out_valid=0 and overrun=0.
REQ-019 Reset SHALL set every section to pass-through: b0=ONE, b1=b2=a1=a2=0.
REQ-020 Reset asserted mid-RUN SHALL abort the sample with no out_valid; reset SHALL take priority over all other inputs.

Verification
REQ-021 Passthrough, with the bench modelling the biquad and NSEC=4: after reset, sample 27'h0100000 at edge T -> out_valid after T+5 with out_data=27'h0100000.
REQ-022 Gain: set b0=27'h0400000 (0.5) in all 4 sections, then send 27'h0800000 -> out_data=27'h0080000.
REQ-023 History: section 0 with b0=0, b1=ONE, other sections passthrough; send samples 27'h0100000 then 0 -> outputs 0, then 27'h0100000. After flush, send 0 -> output 0.
REQ-024 Stall/overrun: cfg_we held asserted during RUN -> cfg_ack=0 until IDLE, then exactly 1 commit. sample_valid during RUN -> dropped and overrun=1.
REQ-025 Reset during RUN with sec=2 -> no out_valid; state IDLE, history=0 and coefficients pass-through on the next cycle.

Source files
------------

// File: rtl/sos_cascade_sched.sv
// rtl/sos_cascade_sched.sv - time-multiplexed scheduler for a cascade of biquad sections
// Feeds one shared biquad datapath a section per cycle and owns all coefficient/history state.
module sos_cascade_sched #(
  parameter int NSEC = 4,
  parameter int W = 27,
  parameter logic [W-1:0] ONE = 27'h0800000
) (
  input  logic         aud_clk,
  input  logic         reset,
  input  logic         sample_valid,
  input  logic [W-1:0] sample_in,
  output logic         sample_ready,
  input  logic         flush,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_sec,
  input  logic [2:0]   cfg_idx,
  input  logic [W-1:0] cfg_data,
  output logic         cfg_ack,
  output logic [W-1:0] dp_x,
  output logic [W-1:0] dp_x1,
  output logic [W-1:0] dp_x2,
  output logic [W-1:0] dp_y1,
  output logic [W-1:0] dp_y2,
  output logic [W-1:0] dp_b0,
  output logic [W-1:0] dp_b1,
  output logic [W-1:0] dp_b2,
  output logic [W-1:0] dp_a1,
  output logic [W-1:0] dp_a2,
  input  logic [W-1:0] dp_y,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] LAST_SEC = 3'(NSEC - 1);
  localparam logic [3:0] NSEC_W   = 4'(NSEC);

  state_t state, next_state;
  logic [2:0]   sec;
  logic [W-1:0] cur;

  // Storage is sized for the 3-bit section address; slots >= NSEC never leave reset values.
  logic [W-1:0] c_b0 [0:7];
  logic [W-1:0] c_b1 [0:7];
  logic [W-1:0] c_b2 [0:7];
  logic [W-1:0] c_a1 [0:7];
  logic [W-1:0] c_a2 [0:7];
  logic [W-1:0] h_x1 [0:7];
  logic [W-1:0] h_x2 [0:7];
  logic [W-1:0] h_y1 [0:7];
  logic [W-1:0] h_y2 [0:7];

  logic cfg_in_range;

  assign sample_ready = (state == IDLE);
  assign cfg_ack      = cfg_we && (state == IDLE);
  assign cfg_in_range = ({1'b0, cfg_sec} < NSEC_W) && (cfg_idx <= 3'd4);

  always_ff @(posedge aud_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sample_valid && !flush) next_state = RUN;
      RUN:     if (sec == LAST_SEC) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    dp_x  = '0;
    dp_x1 = '0;
    dp_x2 = '0;
    dp_y1 = '0;
    dp_y2 = '0;
    dp_b0 = '0;
    dp_b1 = '0;
    dp_b2 = '0;
    dp_a1 = '0;
    dp_a2 = '0;
    if (state == RUN) begin
      dp_x  = cur;
      dp_x1 = h_x1[sec];
      dp_x2 = h_x2[sec];
      dp_y1 = h_y1[sec];
      dp_y2 = h_y2[sec];
      dp_b0 = c_b0[sec];
      dp_b1 = c_b1[sec];
      dp_b2 = c_b2[sec];
      dp_a1 = c_a1[sec];
      dp_a2 = c_a2[sec];
    end
  end

  always_ff @(posedge aud_clk) begin
    if (reset) begin
      sec       <= '0;
      cur       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        c_b0[i] <= ONE;
        c_b1[i] <= '0;
        c_b2[i] <= '0;
        c_a1[i] <= '0;
        c_a2[i] <= '0;
        h_x1[i] <= '0;
        h_x2[i] <= '0;
        h_y1[i] <= '0;
        h_y2[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;

      // Out-of-range writes are still acked so the requester never deadlocks.
      if (cfg_ack && cfg_in_range) begin
        case (cfg_idx)
          3'd0:    c_b0[cfg_sec] <= cfg_data;
          3'd1:    c_b1[cfg_sec] <= cfg_data;
          3'd2:    c_b2[cfg_sec] <= cfg_data;
          3'd3:    c_a1[cfg_sec] <= cfg_data;
          3'd4:    c_a2[cfg_sec] <= cfg_data;
          default: ;
        endcase
      end

      if (sample_valid && ((state != IDLE) || flush)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (flush) begin
            for (int i = 0; i < 8; i++) begin
              h_x1[i] <= '0;
              h_x2[i] <= '0;
              h_y1[i] <= '0;
              h_y2[i] <= '0;
            end
          end else if (sample_valid) begin
            cur <= sample_in;
            sec <= '0;
          end
        end
        RUN: begin
          h_x2[sec] <= h_x1[sec];
          h_x1[sec] <= cur;
          h_y2[sec] <= h_y1[sec];
          h_y1[sec] <= dp_y;
          cur       <= dp_y;
          sec       <= sec + 3'd1;
        end
        DONE: begin
          out_data  <= cur;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sos_cascade_sched.sv
// tb/tb_sos_cascade_sched.sv - directed-vector bench for sos_cascade_sched
// Models the external biquad datapath in Q4.23 and checks hand-computed cascade outputs.
module tb_sos_cascade_sched;

  localparam int NSEC = 4;
  localparam int W = 27;
  localparam logic [W-1:0] ONE = 27'h0800000;
  localparam logic [W-1:0] HALF = 27'h0400000;
  localparam logic [W-1:0] NEG_HALF = 27'h7C00000;

  logic aud_clk = 1'b0;
  logic reset = 1'b1;
  logic sample_valid = 1'b0;
  logic [W-1:0] sample_in = '0;
  logic sample_ready;
  logic flush = 1'b0;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_sec = '0;
  logic [2:0] cfg_idx = '0;
  logic [W-1:0] cfg_data = '0;
  logic cfg_ack;
  logic [W-1:0] dp_x, dp_x1, dp_x2, dp_y1, dp_y2;
  logic [W-1:0] dp_b0, dp_b1, dp_b2, dp_a1, dp_a2;
  logic [W-1:0] dp_y;
  logic out_valid;
  logic [W-1:0] out_data;
  logic overrun;

  int checks = 0;
  int failures = 0;

  sos_cascade_sched #(.NSEC(NSEC), .W(W), .ONE(ONE)) dut (
    .aud_clk(aud_clk), .reset(reset),
    .sample_valid(sample_valid), .sample_in(sample_in), .sample_ready(sample_ready),
    .flush(flush),
    .cfg_we(cfg_we), .cfg_sec(cfg_sec), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .dp_x(dp_x), .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_y1(dp_y1), .dp_y2(dp_y2),
    .dp_b0(dp_b0), .dp_b1(dp_b1), .dp_b2(dp_b2), .dp_a1(dp_a1), .dp_a2(dp_a2),
    .dp_y(dp_y),
    .out_valid(out_valid), .out_data(out_data), .overrun(overrun)
  );

  always #5 aud_clk = ~aud_clk;

  function automatic logic signed [63:0] sx(input logic [W-1:0] v);
    return {{(64-W){v[W-1]}}, v};
  endfunction

  logic signed [63:0] acc;
  always_comb begin
    acc = (sx(dp_b0) * sx(dp_x) + sx(dp_b1) * sx(dp_x1) + sx(dp_b2) * sx(dp_x2)
           - sx(dp_a1) * sx(dp_y1) - sx(dp_a2) * sx(dp_y2)) >>> 23;
    dp_y = acc[W-1:0];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge aud_clk);
    #1 reset = 1'b0;
  endtask

  task automatic do_cfg(input logic [2:0] s, input logic [2:0] i, input logic [W-1:0] d);
    cfg_we = 1'b1;
    cfg_sec = s;
    cfg_idx = i;
    cfg_data = d;
    @(negedge aud_clk);
    chk("cfg_ack_idle", cfg_ack, 1'b1);
    @(posedge aud_clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge aud_clk);
    #1 flush = 1'b0;
  endtask

  // Called just after the accept edge T; counts edges until out_valid is seen.
  task automatic wait_out(input logic [W-1:0] exp);
    int k = 0;
    bit seen = 0;
    while (!seen && k < 20) begin
      @(posedge aud_clk);
      #1;
      k++;
      if (out_valid) seen = 1;
    end
    chk("out_latency", k, NSEC + 1);
    chk("out_data", out_data, exp);
    @(posedge aud_clk);
    #1;
    chk("out_valid_pulse", out_valid, 1'b0);
    chk("out_data_hold", out_data, exp);
  endtask

  task automatic do_sample(input logic [W-1:0] x, input logic [W-1:0] exp);
    sample_valid = 1'b1;
    sample_in = x;
    @(negedge aud_clk);
    chk("sample_ready", sample_ready, 1'b1);
    @(posedge aud_clk);
    #1 sample_valid = 1'b0;
    wait_out(exp);
  endtask

  task automatic count_out_valid(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge aud_clk);
      if (out_valid) n++;
    end
  endtask

  typedef enum logic [1:0] {K_CFG, K_SMP, K_FLUSH} kind_t;
  typedef struct {
    kind_t      kind;
    logic [2:0] sec;
    logic [2:0] idx;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int acks;
    int nv;

    // Out-of-range writes first: any aliasing would break the passthrough samples.
    vecs.push_back('{K_CFG, 3'd4, 3'd0, 27'h0, 27'h0});
    vecs.push_back('{K_CFG, 3'd7, 3'd0, 27'h0, 27'h0});
    vecs.push_back('{K_CFG, 3'd0, 3'd5, ONE, 27'h0});
    vecs.push_back('{K_CFG, 3'd0, 3'd7, ONE, 27'h0});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0100000, 27'h0100000});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h7F00000, 27'h7F00000});
    for (int s = 0; s < NSEC; s++) vecs.push_back('{K_CFG, 3'(s), 3'd0, HALF, 27'h0});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0800000, 27'h0080000});
    vecs.push_back('{K_CFG, 3'd0, 3'd0, 27'h0, 27'h0});
    vecs.push_back('{K_CFG, 3'd0, 3'd1, ONE, 27'h0});
    for (int s = 1; s < NSEC; s++) vecs.push_back('{K_CFG, 3'(s), 3'd0, ONE, 27'h0});
    vecs.push_back('{K_FLUSH, 3'd0, 3'd0, 27'h0, 27'h0});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0100000, 27'h0});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0, 27'h0100000});
    vecs.push_back('{K_FLUSH, 3'd0, 3'd0, 27'h0, 27'h0});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0, 27'h0});
    vecs.push_back('{K_CFG, 3'd0, 3'd1, 27'h0, 27'h0});
    vecs.push_back('{K_CFG, 3'd0, 3'd2, ONE, 27'h0});
    vecs.push_back('{K_FLUSH, 3'd0, 3'd0, 27'h0, 27'h0});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0100000, 27'h0});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0, 27'h0});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0, 27'h0100000});
    vecs.push_back('{K_CFG, 3'd0, 3'd2, 27'h0, 27'h0});
    vecs.push_back('{K_CFG, 3'd0, 3'd0, ONE, 27'h0});
    vecs.push_back('{K_CFG, 3'd0, 3'd4, NEG_HALF, 27'h0});
    vecs.push_back('{K_FLUSH, 3'd0, 3'd0, 27'h0, 27'h0});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0100000, 27'h0100000});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0, 27'h0});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0, 27'h0080000});
    vecs.push_back('{K_CFG, 3'd0, 3'd4, 27'h0, 27'h0});
    vecs.push_back('{K_CFG, 3'd0, 3'd3, NEG_HALF, 27'h0});
    vecs.push_back('{K_FLUSH, 3'd0, 3'd0, 27'h0, 27'h0});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0100000, 27'h0100000});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0, 27'h0080000});
    vecs.push_back('{K_SMP, 3'd0, 3'd0, 27'h0, 27'h0040000});

    do_reset();
    @(negedge aud_clk);
    chk("rst_ready", sample_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 27'h0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_dp_x", dp_x, 27'h0);
    chk("rst_dp_b0_idle", dp_b0, 27'h0);
    chk("rst_cfg_ack", cfg_ack, 1'b0);
    @(posedge aud_clk);
    #1;

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_CFG:   do_cfg(vecs[i].sec, vecs[i].idx, vecs[i].data);
        K_SMP:   do_sample(vecs[i].data, vecs[i].exp);
        default: do_flush();
      endcase
    end

    // cfg write held through a RUN: stalls until IDLE, commits once; mid-RUN sample is dropped.
    do_reset();
    sample_valid = 1'b1;
    sample_in = 27'h0100000;
    @(posedge aud_clk);
    #1 sample_valid = 1'b0;
    cfg_we = 1'b1;
    cfg_sec = 3'd0;
    cfg_idx = 3'd0;
    cfg_data = HALF;
    acks = 0;
    for (int k = 0; k <= NSEC + 1; k++) begin
      if (k == 1) begin
        sample_valid = 1'b1;
        sample_in = 27'h0333333;
      end else begin
        sample_valid = 1'b0;
      end
      @(negedge aud_clk);
      if (cfg_ack) acks++;
      if (k == NSEC + 1) begin
        chk("stall_ack_at_idle", cfg_ack, 1'b1);
        chk("stall_out_valid", out_valid, 1'b1);
        chk("stall_out_data", out_data, 27'h0100000);
      end
      @(posedge aud_clk);
      #1;
    end
    cfg_we = 1'b0;
    sample_valid = 1'b0;
    chk("stall_ack_count", acks, 1);
    chk("overrun_sticky", overrun, 1'b1);
    do_sample(27'h0800000, 27'h0400000);
    chk("overrun_still_set", overrun, 1'b1);

    // Reset while section 2 is active aborts the sample and restores passthrough state.
    do_cfg(3'd1, 3'd0, HALF);
    sample_valid = 1'b1;
    sample_in = 27'h0200000;
    @(posedge aud_clk);
    #1 sample_valid = 1'b0;
    repeat (2) begin
      @(posedge aud_clk);
      #1;
    end
    reset = 1'b1;
    @(posedge aud_clk);
    #1 reset = 1'b0;
    chk("abort_ready", sample_ready, 1'b1);
    chk("abort_overrun", overrun, 1'b0);
    chk("abort_out_data", out_data, 27'h0);
    count_out_valid(NSEC + 4, nv);
    chk("abort_no_out_valid", nv, 0);
    @(posedge aud_clk);
    #1;
    sample_valid = 1'b1;
    sample_in = 27'h0100000;
    @(posedge aud_clk);
    #1 sample_valid = 1'b0;
    @(negedge aud_clk);
    chk("abort_dp_x", dp_x, 27'h0100000);
    chk("abort_dp_x1", dp_x1, 27'h0);
    chk("abort_dp_y1", dp_y1, 27'h0);
    chk("abort_dp_b0", dp_b0, ONE);
    wait_out(27'h0100000);

    // Flush in IDLE drops a coincident sample and flags overrun.
    flush = 1'b1;
    sample_valid = 1'b1;
    sample_in = 27'h0100000;
    @(posedge aud_clk);
    #1;
    flush = 1'b0;
    sample_valid = 1'b0;
    chk("flush_drop_ready", sample_ready, 1'b1);
    chk("flush_drop_overrun", overrun, 1'b1);
    count_out_valid(NSEC + 4, nv);
    chk("flush_drop_no_out", nv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
